// File: rtl/rf_wb_pkg.sv
// Shared widths and the writeback entry type for the RF writeback stage.
package rf_wb_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One queued register-file write.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of writeback entries; pointers wrap modulo DEPTH.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    din,
    input  logic                         pop,
    output wb_entry_t                    dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges the single-cycle primary result and the queued long-latency result
// onto one register-file write port, and tracks registers still awaiting a
// long-latency writeback so decode can stall on them.
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DATA_W = RF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pri_wb_en,
    input  logic [ADDR_W-1:0]           pri_wb_addr,
    input  logic [DATA_W-1:0]           pri_wb_data,
    input  logic                        sec_valid,
    output logic                        sec_ready,
    input  logic [ADDR_W-1:0]           sec_addr,
    input  logic [DATA_W-1:0]           sec_data,
    input  logic                        issue_en,
    input  logic [ADDR_W-1:0]           issue_rd,
    input  logic [ADDR_W-1:0]           chk_rs1,
    input  logic [ADDR_W-1:0]           chk_rs2,
    input  logic [ADDR_W-1:0]           chk_rd,
    output logic                        hazard,
    output logic                        rg_wrt_en,
    output logic [ADDR_W-1:0]           rg_wrt_addr,
    output logic [DATA_W-1:0]           rg_wrt_data,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        idle
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic             pri_eff;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_next;

    // Writes to x0 are dropped everywhere; reset also masks the primary path.
    assign pri_eff   = !reset && pri_wb_en && (pri_wb_addr != ADDR_W'(REG_ZERO));
    assign sec_ready = !reset && !fifo_full;
    assign fifo_push = sec_valid && sec_ready && (sec_addr != ADDR_W'(REG_ZERO));
    assign fifo_pop  = !reset && !pri_eff && !fifo_empty;

    assign push_entry.addr = RF_ADDR_W'(sec_addr);
    assign push_entry.data = RF_DATA_W'(sec_data);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Write-port mux: primary first, otherwise drain the queue head.
    always_comb begin
        rg_wrt_en   = 1'b0;
        rg_wrt_addr = '0;
        rg_wrt_data = '0;
        if (pri_eff) begin
            rg_wrt_en   = 1'b1;
            rg_wrt_addr = pri_wb_addr;
            rg_wrt_data = pri_wb_data;
        end else if (fifo_pop) begin
            rg_wrt_en   = 1'b1;
            rg_wrt_addr = ADDR_W'(head.addr);
            rg_wrt_data = DATA_W'(head.data);
        end
    end

    // Scoreboard update: clear on drain, then set on issue so a same-cycle set wins.
    always_comb begin
        pending_next = pending;
        if (fifo_pop) begin
            pending_next[ADDR_W'(head.addr)] = 1'b0;
        end
        if (issue_en && (issue_rd != ADDR_W'(REG_ZERO))) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];
    assign idle   = (fifo_count == '0) && (pending == '0);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter. Inputs change at the falling edge,
// outputs are sampled 1ns later, state commits at the following rising edge.
module tb_rf_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        pri_wb_en;
    logic [4:0]  pri_wb_addr;
    logic [31:0] pri_wb_data;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [2:0]  fifo_count;
    logic        idle;

    int errors = 0;
    int checks = 0;

    rf_writeback_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pri_wb_en   (pri_wb_en),
        .pri_wb_addr (pri_wb_addr),
        .pri_wb_data (pri_wb_data),
        .sec_valid   (sec_valid),
        .sec_ready   (sec_ready),
        .sec_addr    (sec_addr),
        .sec_data    (sec_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .hazard      (hazard),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_addr (rg_wrt_addr),
        .rg_wrt_data (rg_wrt_data),
        .fifo_count  (fifo_count),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        pri_wb_en = 0; pri_wb_addr = 0; pri_wb_data = 0;
        sec_valid = 0; sec_addr = 0; sec_data = 0;
        issue_en = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    // Primary held busy writing r3 so the queue cannot drain.
    task automatic pri_busy();
        pri_wb_en = 1; pri_wb_addr = 5'd3; pri_wb_data = 32'h33;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        pri_wb_en = 1; pri_wb_addr = 5'd5; pri_wb_data = 32'h1;
        sec_valid = 1; sec_addr = 5'd6;
        @(negedge clk); #1;
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL reset_wrt_en got=%0b exp=0", rg_wrt_en); end
        checks++; if (sec_ready !== 1'b0) begin errors++; $display("FAIL reset_sec_ready got=%0b exp=0", sec_ready); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b exp=1", idle); end
        @(negedge clk);
        clear_inputs();
        reset = 0;
    endtask

    task automatic test_primary();
        @(negedge clk);
        pri_wb_en = 1; pri_wb_addr = 5'd5; pri_wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (rg_wrt_en !== 1'b1) begin errors++; $display("FAIL pri_en got=%0b exp=1", rg_wrt_en); end
        checks++; if (rg_wrt_addr !== 5'd5) begin errors++; $display("FAIL pri_addr got=%0d exp=5", rg_wrt_addr); end
        checks++; if (rg_wrt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pri_data got=%h exp=deadbeef", rg_wrt_data); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pri_fifo_untouched got=%0d exp=0", fifo_count); end
        checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_addr !== 5'd0 || rg_wrt_data !== 32'd0) begin
            errors++; $display("FAIL pri_quiet got en=%0b addr=%0d data=%h exp 0/0/0", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
    endtask

    task automatic test_queue_drain();
        @(negedge clk);
        pri_busy();
        issue_en = 1; issue_rd = 5'd7;
        #1;
        checks++; if (rg_wrt_addr !== 5'd3) begin errors++; $display("FAIL qd_pri_wins got=%0d exp=3", rg_wrt_addr); end
        @(negedge clk);
        issue_en = 0; chk_rs1 = 5'd7;
        sec_valid = 1; sec_addr = 5'd7; sec_data = 32'h1234;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL qd_hazard got=%0b exp=1", hazard); end
        checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL qd_ready got=%0b exp=1", sec_ready); end
        @(negedge clk);
        sec_valid = 0;
        #1;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL qd_count got=%0d exp=1", fifo_count); end
        checks++; if (rg_wrt_addr !== 5'd3) begin errors++; $display("FAIL qd_busy_addr got=%0d exp=3", rg_wrt_addr); end
        @(negedge clk);
        pri_wb_en = 0;
        #1;
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_addr !== 5'd7 || rg_wrt_data !== 32'h1234) begin
            errors++; $display("FAIL qd_drain got en=%0b addr=%0d data=%h exp 1/7/1234", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
        @(negedge clk); #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL qd_pending_clr got=%0b exp=0", hazard); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL qd_idle got=%0b exp=1", idle); end
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL qd_no_write got=%0b exp=0", rg_wrt_en); end
        clear_inputs();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pri_busy();
            sec_valid = 1; sec_addr = 5'(10 + i); sec_data = 32'hA0 + 32'(i);
            #1;
            checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d got=%0b exp=1", i, sec_ready); end
        end
        @(negedge clk);
        sec_addr = 5'd14; sec_data = 32'hA4;
        #1;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        checks++; if (sec_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got=%0b exp=0", sec_ready); end
        @(negedge clk);
        sec_valid = 0;
        pri_wb_en = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_addr !== 5'(10 + i) || rg_wrt_data !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL full_drain%0d got en=%0b addr=%0d data=%h exp 1/%0d/%h",
                                   i, rg_wrt_en, rg_wrt_addr, rg_wrt_data, 10 + i, 32'hA0 + 32'(i));
            end
        end
        @(negedge clk); #1;
        checks++; if (rg_wrt_en !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL full_empty got en=%0b count=%0d exp 0/0", rg_wrt_en, fifo_count);
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        @(negedge clk);
        pri_busy();
        sec_valid = 1; sec_addr = 5'd20; sec_data = 32'h55;
        @(negedge clk);
        sec_valid = 0;
        pri_wb_en = 1; pri_wb_addr = 5'd0; pri_wb_data = 32'hFFFF;
        #1;
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_addr !== 5'd20 || rg_wrt_data !== 32'h55) begin
            errors++; $display("FAIL x0_pri_drain got en=%0b addr=%0d data=%h exp 1/20/55", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
        @(negedge clk);
        pri_busy();
        sec_valid = 1; sec_addr = 5'd0; sec_data = 32'h77;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL x0_popped got=%0d exp=0", fifo_count); end
        checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", sec_ready); end
        @(negedge clk);
        sec_valid = 0;
        issue_en = 1; issue_rd = 5'd0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL x0_push_dropped got=%0d exp=0", fifo_count); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (idle !== 1'b1 || hazard !== 1'b0) begin
            errors++; $display("FAIL x0_issue_ignored got idle=%0b hazard=%0b exp 1/0", idle, hazard);
        end
    endtask

    task automatic test_push_pop();
        @(negedge clk);
        pri_busy();
        sec_valid = 1; sec_addr = 5'd9; sec_data = 32'h99;
        @(negedge clk);
        sec_addr = 5'd22; sec_data = 32'h22;
        @(negedge clk);
        pri_wb_en = 0;
        sec_addr = 5'd23; sec_data = 32'h23;
        issue_en = 1; issue_rd = 5'd9;
        #1;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_pre_count got=%0d exp=2", fifo_count); end
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_addr !== 5'd9 || rg_wrt_data !== 32'h99) begin
            errors++; $display("FAIL pp_pop got en=%0b addr=%0d data=%h exp 1/9/99", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
        @(negedge clk);
        sec_valid = 0; issue_en = 0; chk_rs2 = 5'd9;
        #1;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_count got=%0d exp=2", fifo_count); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL pp_set_wins got=%0b exp=1", hazard); end
        checks++; if (rg_wrt_addr !== 5'd22 || rg_wrt_data !== 32'h22) begin
            errors++; $display("FAIL pp_order0 got addr=%0d data=%h exp 22/22", rg_wrt_addr, rg_wrt_data);
        end
        @(negedge clk); #1;
        checks++; if (rg_wrt_addr !== 5'd23 || rg_wrt_data !== 32'h23) begin
            errors++; $display("FAIL pp_order1 got addr=%0d data=%h exp 23/23", rg_wrt_addr, rg_wrt_data);
        end
        @(negedge clk); #1;
        checks++; if (idle !== 1'b0 || hazard !== 1'b1) begin
            errors++; $display("FAIL pp_still_pending got idle=%0b hazard=%0b exp 0/1", idle, hazard);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        pri_busy();
        issue_en = 1; issue_rd = 5'd4;
        sec_valid = 1; sec_addr = 5'd4; sec_data = 32'h44;
        @(negedge clk);
        issue_rd = 5'd5;
        sec_addr = 5'd5; sec_data = 32'h45;
        @(negedge clk);
        issue_en = 0;
        sec_addr = 5'd6; sec_data = 32'h46;
        @(negedge clk);
        sec_valid = 0;
        chk_rs1 = 5'd4; chk_rd = 5'd5;
        #1;
        checks++; if (fifo_count !== 3'd3 || hazard !== 1'b1) begin
            errors++; $display("FAIL ar_setup got count=%0d hazard=%0b exp 3/1", fifo_count, hazard);
        end
        pri_wb_en = 0;
        #1;
        reset = 1;
        #1;
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL ar_wrt_en got=%0b exp=0", rg_wrt_en); end
        checks++; if (idle !== 1'b1 || fifo_count !== 3'd0 || hazard !== 1'b0 || sec_ready !== 1'b0) begin
            errors++; $display("FAIL ar_state got idle=%0b count=%0d hazard=%0b ready=%0b exp 1/0/0/0",
                               idle, fifo_count, hazard, sec_ready);
        end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rg_wrt_en !== 1'b0 || fifo_count !== 3'd0 || idle !== 1'b1) begin
                errors++; $display("FAIL ar_after%0d got en=%0b count=%0d idle=%0b exp 0/0/1", i, rg_wrt_en, fifo_count, idle);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_primary();
        test_queue_drain();
        test_full();
        test_x0();
        test_push_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
